// File: rtl/fpu_add_sub_pipe.sv
// Three-stage floating-point adder/subtractor with valid/ready handshake, RNE rounding,
// flush-to-zero subnormals, exception flags {NV,OF,UF,NX} and a sideband tag.
module fpu_add_sub_pipe #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int TAG_W = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_valid,
   output logic                       o_ready,
   input  logic                       i_add_sub,
   input  logic [EXP_W+MAN_W:0]       i_a,
   input  logic [EXP_W+MAN_W:0]       i_b,
   input  logic [TAG_W-1:0]           i_tag,
   output logic                       o_valid,
   input  logic                       i_ready,
   output logic [EXP_W+MAN_W:0]       o_result,
   output logic [3:0]                 o_flags,
   output logic [TAG_W-1:0]           o_tag
);
   localparam int W   = 1 + EXP_W + MAN_W;
   localparam int FW  = MAN_W + 4;          // hidden, fraction, guard, round, sticky
   localparam int SW  = MAN_W + 5;          // FW plus carry
   localparam int SHW = $clog2(FW);
   localparam int XW  = EXP_W + 8;          // signed exponent headroom for normalisation
   localparam logic signed [XW-1:0] EMAX = XW'((1 << EXP_W) - 1);
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   logic en;
   logic v1_q, v2_q, v3_q;
   assign en      = i_ready || !v3_q;
   assign o_ready = en;
   assign o_valid = v3_q;

   // ---------------- stage 1: classify, swap, align ----------------
   logic              sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
   logic [EXP_W-1:0]  ea, eb, big_e, sm_e, diff;
   logic [MAN_W-1:0]  fa, fb, big_f, sm_f;
   logic              big_s, big_z, sm_z;
   logic [W-2:0]      mag_a, mag_b;
   logic [SHW-1:0]    sh;
   logic [FW-1:0]     ext_sm, shifted, mask, s1_big_d, s1_sm_d;
   logic              lost;
   logic              s1_spec_d;
   logic [W-1:0]      s1_spec_res_d;
   logic [3:0]        s1_spec_flg_d;

   assign sa = i_a[W-1];
   assign sb = i_b[W-1] ^ i_add_sub;
   assign ea = i_a[W-2:MAN_W];
   assign eb = i_b[W-2:MAN_W];
   assign fa = i_a[MAN_W-1:0];
   assign fb = i_b[MAN_W-1:0];
   assign a_zero = (ea == '0);
   assign b_zero = (eb == '0);
   assign a_inf  = (ea == '1) && (fa == '0);
   assign b_inf  = (eb == '1) && (fb == '0);
   assign a_nan  = (ea == '1) && (fa != '0);
   assign b_nan  = (eb == '1) && (fb != '0);
   assign mag_a  = a_zero ? '0 : i_a[W-2:0];
   assign mag_b  = b_zero ? '0 : i_b[W-2:0];
   assign swap   = (mag_b > mag_a);

   always_comb begin
      big_s = swap ? sb     : sa;
      big_e = swap ? eb     : ea;
      big_f = swap ? fb     : fa;
      big_z = swap ? b_zero : a_zero;
      sm_e  = swap ? ea     : eb;
      sm_f  = swap ? fa     : fb;
      sm_z  = swap ? a_zero : b_zero;
      diff  = big_e - sm_e;
      if (32'(diff) > 32'(FW - 1)) sh = SHW'(FW - 1);
      else                         sh = SHW'(diff);
      s1_big_d = big_z ? '0 : {1'b1, big_f, 3'b000};
      ext_sm   = sm_z  ? '0 : {1'b1, sm_f, 3'b000};
      shifted  = ext_sm >> sh;
      mask     = (FW'(1) << sh) - FW'(1);
      lost     = |(ext_sm & mask);
      s1_sm_d  = {shifted[FW-1:1], shifted[0] | lost};
   end

   always_comb begin
      s1_spec_d     = 1'b0;
      s1_spec_res_d = '0;
      s1_spec_flg_d = 4'b0000;
      if (a_nan || b_nan) begin
         s1_spec_d     = 1'b1;
         s1_spec_res_d = QNAN;
      end else if (a_inf && b_inf && (sa != sb)) begin
         s1_spec_d     = 1'b1;
         s1_spec_res_d = QNAN;
         s1_spec_flg_d = 4'b1000;
      end else if (a_inf) begin
         s1_spec_d     = 1'b1;
         s1_spec_res_d = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (b_inf) begin
         s1_spec_d     = 1'b1;
         s1_spec_res_d = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (a_zero && b_zero) begin
         s1_spec_d     = 1'b1;
         s1_spec_res_d = {sa & sb, {(W-1){1'b0}}};
      end
   end

   logic              s1_sign_q, s1_sub_q, s1_spec_q;
   logic [EXP_W-1:0]  s1_exp_q;
   logic [FW-1:0]     s1_big_q, s1_sm_q;
   logic [W-1:0]      s1_spec_res_q;
   logic [3:0]        s1_spec_flg_q;
   logic [TAG_W-1:0]  s1_tag_q;

   // ---------------- stage 2: add/subtract magnitudes, leading-one detect ----------------
   logic [SW-1:0]     s2_sum_d;
   logic [SHW-1:0]    s2_lz_d;
   logic              s2_zero_d;

   assign s2_sum_d  = s1_sub_q ? ({1'b0, s1_big_q} - {1'b0, s1_sm_q})
                               : ({1'b0, s1_big_q} + {1'b0, s1_sm_q});
   assign s2_zero_d = (s2_sum_d == '0);

   always_comb begin
      s2_lz_d = '0;
      for (int i = 0; i < FW; i++)
         if (s2_sum_d[i]) s2_lz_d = SHW'(FW - 1 - i);
   end

   logic              s2_sign_q, s2_zero_q, s2_spec_q;
   logic [EXP_W-1:0]  s2_exp_q;
   logic [SW-1:0]     s2_sum_q;
   logic [SHW-1:0]    s2_lz_q;
   logic [W-1:0]      s2_spec_res_q;
   logic [3:0]        s2_spec_flg_q;
   logic [TAG_W-1:0]  s2_tag_q;

   // ---------------- stage 3: normalise, round, pack ----------------
   logic signed [XW-1:0] e_base, e_n, e_f;
   logic [FW-1:0]        norm;
   logic [MAN_W:0]       mant;
   logic [MAN_W+1:0]     mant_r;
   logic [MAN_W-1:0]     frac;
   logic                 rnd, inexact;
   logic [W-1:0]         res_d;
   logic [3:0]           flags_d;

   always_comb begin
      e_base = signed'(XW'(s2_exp_q));
      if (s2_sum_q[SW-1]) begin
         norm = {s2_sum_q[SW-1:2], |s2_sum_q[1:0]};
         e_n  = e_base + XW'(1);
      end else begin
         norm = s2_sum_q[FW-1:0] << s2_lz_q;
         e_n  = e_base - signed'(XW'(s2_lz_q));
      end
      mant    = norm[FW-1:3];
      inexact = |norm[2:0];
      rnd     = norm[2] & (norm[1] | norm[0] | mant[0]);
      mant_r  = {1'b0, mant} + (MAN_W+2)'(rnd);
      if (mant_r[MAN_W+1]) begin
         e_f  = e_n + XW'(1);
         frac = mant_r[MAN_W:1];
      end else begin
         e_f  = e_n;
         frac = mant_r[MAN_W-1:0];
      end

      if (s2_spec_q) begin
         res_d   = s2_spec_res_q;
         flags_d = s2_spec_flg_q;
      end else if (s2_zero_q) begin
         res_d   = '0;
         flags_d = 4'b0000;
      end else if (e_f >= EMAX) begin
         res_d   = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flags_d = 4'b0101;
      end else if (e_f[XW-1] || (e_f == '0)) begin
         res_d   = {s2_sign_q, {(W-1){1'b0}}};
         flags_d = 4'b0011;
      end else begin
         res_d   = {s2_sign_q, e_f[EXP_W-1:0], frac};
         flags_d = {3'b000, inexact};
      end
   end

   // Valid bits and output registers are reset; interior data is gated by valid.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         v1_q     <= 1'b0;
         v2_q     <= 1'b0;
         v3_q     <= 1'b0;
         o_result <= '0;
         o_flags  <= '0;
         o_tag    <= '0;
      end else if (en) begin
         v1_q <= i_valid;
         v2_q <= v1_q;
         v3_q <= v2_q;
         if (v2_q) begin
            o_result <= res_d;
            o_flags  <= flags_d;
            o_tag    <= s2_tag_q;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (en) begin
         if (i_valid) begin
            s1_sign_q     <= big_s;
            s1_exp_q      <= big_e;
            s1_big_q      <= s1_big_d;
            s1_sm_q       <= s1_sm_d;
            s1_sub_q      <= (sa != sb);
            s1_spec_q     <= s1_spec_d;
            s1_spec_res_q <= s1_spec_res_d;
            s1_spec_flg_q <= s1_spec_flg_d;
            s1_tag_q      <= i_tag;
         end
         if (v1_q) begin
            s2_sign_q     <= s1_sign_q;
            s2_exp_q      <= s1_exp_q;
            s2_sum_q      <= s2_sum_d;
            s2_lz_q       <= s2_lz_d;
            s2_zero_q     <= s2_zero_d;
            s2_spec_q     <= s1_spec_q;
            s2_spec_res_q <= s1_spec_res_q;
            s2_spec_flg_q <= s1_spec_flg_q;
            s2_tag_q      <= s1_tag_q;
         end
      end
   end
endmodule

// File: tb/tb_fpu_add_sub_pipe.sv
// Scoreboard bench: drivers push hand-computed results, monitors pop and compare on handshake.
module tb_fpu_add_sub_pipe;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, i_valid, i_add_sub, i_ready, o_ready, o_valid;
   logic [31:0] a, b, o_result;
   logic [3:0]  tag, o_flags, o_tag;

   logic        h_valid, h_add_sub, h_ready, h_oready, h_ovalid;
   logic [15:0] h_a, h_b, h_result;
   logic [3:0]  h_tag, h_flags, h_otag;

   fpu_add_sub_pipe dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_add_sub(i_add_sub), .i_a(a), .i_b(b), .i_tag(tag),
      .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
      .o_flags(o_flags), .o_tag(o_tag));

   fpu_add_sub_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut_h (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(h_valid), .o_ready(h_oready),
      .i_add_sub(h_add_sub), .i_a(h_a), .i_b(h_b), .i_tag(h_tag),
      .o_valid(h_ovalid), .i_ready(h_ready), .o_result(h_result),
      .o_flags(h_flags), .o_tag(h_otag));

   typedef struct packed { logic [31:0] res; logic [3:0] flg; logic [3:0] tag; } exp_t;
   typedef struct packed { logic [31:0] a; logic [31:0] b; logic op; logic [31:0] r; logic [3:0] f; } vec_t;

   exp_t q[$];
   exp_t hq[$];
   int   pass_cnt = 0;
   int   total_cnt = 0;

   vec_t vecs [14] = '{
      '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'h0},
      '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1},
      '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h5},
      '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'h8},
      '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h0},
      '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'h1},
      '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'h1},
      '{32'h3F7FFFFF, 32'h33000000, 1'b0, 32'h3F800000, 4'h1},
      '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'h3},
      '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'h0},
      '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 4'h0},
      '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'h0},
      '{32'hBF800000, 32'h3F000000, 1'b0, 32'hBF000000, 4'h0},
      '{32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 4'h0}
   };

   // b operand and expected sum for the 1.0 + n stream (n = tag+1)
   logic [31:0] bp_b [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
   logic [31:0] bp_r [8] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                             32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total_cnt++;
      if (act === req) pass_cnt++;
      else $display("FAIL %s: got %0h required %0h", name, act, req);
   endtask

   task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic op,
                       input logic [3:0] t, input logic [31:0] er, input logic [3:0] ef,
                       input bit push);
      bit done;
      a = va; b = vb; i_add_sub = op; tag = t; i_valid = 1'b1;
      done = 0;
      for (int n = 0; n < 100 && !done; n++) begin
         @(negedge clk);
         if (o_ready) begin
            if (push) q.push_back('{er, ef, t});
            @(posedge clk); #1;
            done = 1;
         end
      end
      if (!done) begin
         total_cnt++;
         $display("FAIL send_timeout tag %0d: o_ready stayed 0", t);
      end
   endtask

   task automatic hsend(input logic [15:0] va, input logic [15:0] vb, input logic op,
                        input logic [3:0] t, input logic [15:0] er, input logic [3:0] ef);
      bit done;
      h_a = va; h_b = vb; h_add_sub = op; h_tag = t; h_valid = 1'b1;
      done = 0;
      for (int n = 0; n < 100 && !done; n++) begin
         @(negedge clk);
         if (h_oready) begin
            hq.push_back('{{16'h0, er}, ef, t});
            @(posedge clk); #1;
            done = 1;
         end
      end
      if (!done) begin
         total_cnt++;
         $display("FAIL hsend_timeout tag %0d", t);
      end
   endtask

   initial begin : mon
      exp_t        e;
      bit          hold_v;
      logic [39:0] held;
      hold_v = 0;
      held   = '0;
      forever begin
         @(negedge clk);
         if (hold_v) check("hold_stable", {o_result, o_flags, o_tag}, {24'h0, held});
         hold_v = o_valid && !i_ready && rst_n;
         held   = {o_result, o_flags, o_tag};
         if (o_valid && i_ready) begin
            if (q.size() == 0) begin
               total_cnt++;
               $display("FAIL unexpected_result: got %0h tag %0d required none", o_result, o_tag);
            end else begin
               e = q.pop_front();
               $display("result tag %0d: %08h flags %04b", o_tag, o_result, o_flags);
               check($sformatf("res_tag%0d", e.tag), o_result, e.res);
               check($sformatf("flags_tag%0d", e.tag), o_flags, e.flg);
               check($sformatf("tag_order%0d", e.tag), o_tag, e.tag);
            end
         end
      end
   end

   initial begin : hmon
      exp_t e;
      forever begin
         @(negedge clk);
         if (h_ovalid && h_ready) begin
            if (hq.size() == 0) begin
               total_cnt++;
               $display("FAIL unexpected_half: got %0h required none", h_result);
            end else begin
               e = hq.pop_front();
               $display("half tag %0d: %04h flags %04b", h_otag, h_result, h_flags);
               check($sformatf("h_res_tag%0d", e.tag), h_result, e.res);
               check($sformatf("h_flags_tag%0d", e.tag), h_flags, e.flg);
               check($sformatf("h_tag%0d", e.tag), h_otag, e.tag);
            end
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
      $fatal(1, "timeout");
   end

   initial begin : main
      int lat;
      rst_n = 1'b0; i_valid = 1'b0; i_add_sub = 1'b0; i_ready = 1'b1;
      a = '0; b = '0; tag = '0;
      h_valid = 1'b0; h_add_sub = 1'b0; h_ready = 1'b1; h_a = '0; h_b = '0; h_tag = '0;
      #12;
      check("reset_o_valid", o_valid, 0);
      check("reset_o_ready", o_ready, 1);
      check("reset_outputs", {o_result, o_flags, o_tag}, 0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // basic add with latency measurement
      send(32'h3F800000, 32'h40000000, 1'b0, 4'd5, 32'h40400000, 4'h0, 1);
      i_valid = 1'b0;
      lat = 1;
      while (!o_valid && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", lat, 3);
      repeat (3) @(posedge clk); #1;

      // directed vectors streamed back-to-back
      for (int i = 0; i < 14; i++)
         send(vecs[i].a, vecs[i].b, vecs[i].op, 4'(i), vecs[i].r, vecs[i].f, 1);
      i_valid = 1'b0;
      repeat (6) @(posedge clk); #1;

      // backpressure: downstream stalls for three cycles mid-stream
      fork
         begin
            for (int t = 0; t < 8; t++)
               send(32'h3F800000, bp_b[t], 1'b0, 4'(t), bp_r[t], 4'h0, 1);
            i_valid = 1'b0;
         end
         begin
            repeat (4) @(posedge clk);
            #1 i_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               check("stall_o_ready", o_ready, 0);
            end
            @(posedge clk);
            #1 i_ready = 1'b1;
         end
      join
      repeat (8) @(posedge clk); #1;

      // reset with two operations in flight; neither may emerge
      send(32'h3F800000, 32'h3F800000, 1'b0, 4'd9, 32'h0, 4'h0, 0);
      send(32'h40000000, 32'h40000000, 1'b0, 4'd10, 32'h0, 4'h0, 0);
      i_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("rst_o_valid", o_valid, 0);
      check("rst_o_ready", o_ready, 1);
      check("rst_outputs", {o_result, o_flags, o_tag}, 0);
      #3 rst_n = 1'b1;
      repeat (10) @(posedge clk); #1;
      check("rst_no_output", o_valid, 0);

      // half precision
      hsend(16'h3C00, 16'h3C00, 1'b0, 4'd1, 16'h4000, 4'h0);
      hsend(16'h7BFF, 16'h7BFF, 1'b0, 4'd2, 16'h7C00, 4'h5);
      hsend(16'h3C00, 16'h3C00, 1'b1, 4'd3, 16'h0000, 4'h0);
      h_valid = 1'b0;

      for (int n = 0; n < 50 && (q.size() != 0 || hq.size() != 0); n++)
         @(posedge clk);
      #1;
      check("drain_main", q.size(), 0);
      check("drain_half", hq.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
